// File: rtl/romulus_pkg.sv
// Shared definitions for the Romulus/SKINNY-128-384 block controller.
// Holds the FSM state encoding, block geometry and the round-constant LFSR step.
package romulus_pkg;

    localparam int ROUNDS     = 56;
    localparam int RPC        = 2;
    localparam int WORDS      = 4;
    localparam int RUN_CYCLES = ROUNDS / RPC;

    localparam logic [5:0] RC_INIT = 6'h00;

    typedef enum logic [2:0] {
        IDLE,
        LD_S,
        LD_Y,
        LD_X,
        RUN,
        REVERT,
        OUT
    } state_e;

    // One SKINNY round-constant LFSR step.
    function automatic logic [5:0] rc_step(input logic [5:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

endpackage

// File: rtl/romulus_rc_lfsr.sv
// Round-constant generator producing two SKINNY LFSR steps per clock.
// Ports: clk_i, rst_ni (sync, active-low), clr_i, en_i -> rc1_o, rc2_o.
module romulus_rc_lfsr
    import romulus_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       en_i,
    output logic [5:0] rc1_o,
    output logic [5:0] rc2_o
);

    logic [5:0] rc_q;
    logic [5:0] rc_d;

    assign rc1_o = rc_step(rc_q);
    assign rc2_o = rc_step(rc1_o);

    always_comb begin
        rc_d = rc_q;
        if (clr_i) begin
            rc_d = RC_INIT;
        end else if (en_i) begin
            rc_d = rc2_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rc_q <= RC_INIT;
        end else begin
            rc_q <= rc_d;
        end
    end

endmodule

// File: rtl/romulus_block_ctrl.sv
// Block sequencer for the serial Romulus/SKINNY-128-384 datapath: load, run, revert, output.
// Ports: cmd_* command handshake, pdi/sdi/pdo word handshakes, S/X/Y/Z register controls, constants.
module romulus_block_ctrl
    import romulus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_key,
    input  logic       cmd_tky,
    input  logic       cmd_first,
    input  logic [3:0] cmd_decrypt,
    input  logic [7:0] cmd_domain,
    input  logic       cmd_tk1s,
    input  logic       pdi_valid,
    output logic       pdi_ready,
    input  logic       sdi_valid,
    output logic       sdi_ready,
    output logic       pdo_valid,
    input  logic       pdo_ready,
    output logic       srst,
    output logic       senc,
    output logic       sse,
    output logic       xrst,
    output logic       xenc,
    output logic       xse,
    output logic       yrst,
    output logic       yenc,
    output logic       yse,
    output logic       zrst,
    output logic       zenc,
    output logic       zse,
    output logic       erst,
    output logic       correct_cnt,
    output logic [5:0] constant,
    output logic [5:0] constant2,
    output logic [3:0] decrypt,
    output logic [7:0] domain,
    output logic       tk1s,
    output logic       done
);

    localparam logic [1:0] W_LAST = 2'(WORDS - 1);
    localparam logic [4:0] R_LAST = 5'(RUN_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] wcnt_q, wcnt_d;
    logic [4:0] rcnt_q, rcnt_d;
    logic       clr_q, clr_d;
    logic       xrst_q, xrst_d;
    logic       zrst_q, zrst_d;
    logic       key_q, key_d;
    logic       tky_q, tky_d;
    logic [3:0] dec_q, dec_d;
    logic [7:0] dom_q, dom_d;
    logic       tk1s_q, tk1s_d;
    logic       rc_clr, rc_en;
    logic [5:0] rc1, rc2;

    romulus_rc_lfsr u_rc (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (rc_clr),
        .en_i   (rc_en),
        .rc1_o  (rc1),
        .rc2_o  (rc2)
    );

    assign srst      = clr_q;
    assign xrst      = xrst_q;
    assign yrst      = 1'b0;
    assign zrst      = zrst_q;
    assign erst      = zrst_q;
    assign decrypt   = dec_q;
    assign domain    = dom_q;
    assign tk1s      = tk1s_q;
    assign constant  = (state_q == RUN) ? rc1 : 6'h00;
    assign constant2 = (state_q == RUN) ? rc2 : 6'h00;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        clr_d       = 1'b0;
        xrst_d      = 1'b0;
        zrst_d      = 1'b0;
        key_d       = key_q;
        tky_d       = tky_q;
        dec_d       = dec_q;
        dom_d       = dom_q;
        tk1s_d      = tk1s_q;
        rc_en       = 1'b0;
        cmd_ready   = 1'b0;
        pdi_ready   = 1'b0;
        sdi_ready   = 1'b0;
        pdo_valid   = 1'b0;
        senc        = 1'b0;
        sse         = 1'b0;
        xenc        = 1'b0;
        xse         = 1'b0;
        yenc        = 1'b0;
        yse         = 1'b0;
        zenc        = 1'b0;
        zse         = 1'b0;
        correct_cnt = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    clr_d   = 1'b1;
                    xrst_d  = cmd_key;
                    zrst_d  = cmd_first;
                    key_d   = cmd_key;
                    tky_d   = cmd_tky;
                    dec_d   = cmd_decrypt;
                    dom_d   = cmd_domain;
                    tk1s_d  = cmd_tk1s;
                    wcnt_d  = '0;
                    state_d = LD_S;
                end
            end
            LD_S: begin
                // The clear pulse owns the first LD_S cycle.
                pdi_ready = pdi_valid & ~clr_q;
                sse       = pdi_ready;
                if (pdi_ready) begin
                    wcnt_d = wcnt_q + 2'd1;
                    if (wcnt_q == W_LAST) begin
                        state_d = tky_q ? LD_Y : (key_q ? LD_X : RUN);
                    end
                end
            end
            LD_Y: begin
                pdi_ready = pdi_valid;
                yse       = pdi_ready;
                if (pdi_ready) begin
                    wcnt_d = wcnt_q + 2'd1;
                    if (wcnt_q == W_LAST) begin
                        state_d = key_q ? LD_X : RUN;
                    end
                end
            end
            LD_X: begin
                sdi_ready = sdi_valid;
                xse       = sdi_ready;
                if (sdi_ready) begin
                    wcnt_d = wcnt_q + 2'd1;
                    if (wcnt_q == W_LAST) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                senc   = 1'b1;
                xenc   = 1'b1;
                yenc   = 1'b1;
                zenc   = 1'b1;
                rc_en  = 1'b1;
                rcnt_d = rcnt_q + 5'd1;
                if (rcnt_q == R_LAST) begin
                    state_d = REVERT;
                end
            end
            REVERT: begin
                xenc        = 1'b1;
                xse         = 1'b1;
                yenc        = 1'b1;
                yse         = 1'b1;
                zenc        = 1'b1;
                zse         = 1'b1;
                correct_cnt = 1'b1;
                wcnt_d      = '0;
                state_d     = OUT;
            end
            OUT: begin
                pdo_valid = 1'b1;
                sse       = pdo_ready;
                if (pdo_ready) begin
                    wcnt_d = wcnt_q + 2'd1;
                    if (wcnt_q == W_LAST) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        rc_clr = (state_d == RUN) && (state_q != RUN);
        if (rc_clr) begin
            rcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            clr_q   <= 1'b0;
            xrst_q  <= 1'b0;
            zrst_q  <= 1'b0;
            key_q   <= 1'b0;
            tky_q   <= 1'b0;
            dec_q   <= '0;
            dom_q   <= '0;
            tk1s_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            clr_q   <= clr_d;
            xrst_q  <= xrst_d;
            zrst_q  <= zrst_d;
            key_q   <= key_d;
            tky_q   <= tky_d;
            dec_q   <= dec_d;
            dom_q   <= dom_d;
            tk1s_q  <= tk1s_d;
        end
    end

endmodule
